digi_scan_driver: RTL
=====================

# digi_scan_driver

Memory-mapped producer of the CPU's 12-bit `digi` display bus: four multiplexed active-low common-anode seven-segment digits. The CPU writes a 16-bit hex value and control bits over its peripheral bus. The block time-multiplexes the four digits with a programmable slot length and a blanking gap. Value updates are double-buffered so a frame never shows a torn value.

## Interface
- `SCAN_DIV`, 100000: clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYC`, 16: cycles at the start of each slot with all anodes off; must be < `SCAN_DIV`.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `mem_we`  in  1: register write strobe, one cycle.
- `mem_re`  in  1: register read strobe, one cycle.
- `mem_addr`  in  2: register select.
- `mem_wdata`  in  32: write data.
- `mem_rdata`  out  32: read data, registered.
- `digi`  out  12: `[11:8]` anode one-hot active-low (bit 8 + i = digit i); `[7]` dp active-low; `[6:0]` segments g..a active-low.

## Operation
- **Registers:**
  - addr 0 VALUE: `[15:0]` pending value, R/W; digit i = `VALUE[4i+3:4i]`, digit 0 is rightmost.
  - addr 1 CTRL: `[3:0]` blank mask (1 = digit dark), `[7:4]` dp mask (1 = dp lit), `[8]` enable; R/W.
  - addr 2 STATUS, read-only: `[1:0]` current digit, `[2]` frame_done, sticky and cleared by reading STATUS.
  - addr 3 reads 0; writes to it are ignored.
  - Unused bits read 0.
- **Reset:** VALUE, CTRL, shadow, slot counter, digit index, frame_done, `mem_rdata` all 0; `digi` = 12'hFFF.
- **Disabled** (CTRL[8] = 0):
  - `digi` = 12'hFFF.
  - Counter and digit index held at 0.
  - Shadow (value, blank mask, dp mask) copies pending registers every cycle.
- **Enabled:**
  - Counter counts 0..`SCAN_DIV`-1. At terminal count the digit advances 0→1→2→3→0.
  - On the 3→0 wrap (frame boundary), shadow loads the pending registers and frame_done sets.
- **Slot output:**
  - When counter < `BLANK_CYC`, or the digit is blanked: `digi` = 12'hFFF.
  - Otherwise the anode bit for the digit is 0, the other anodes are 1, dp = ~dpmask[i], and segments = hex decode of the nibble.
- **Hex decode** (gfedcba, active-low): 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
- **Simultaneous events:**
  - Write coincident with the frame boundary: shadow loads the pre-write value; the new value shows from the following frame.
  - STATUS read coincident with the frame boundary: frame_done reads its old value and ends set (set wins over clear).
  - Write clearing enable mid-slot: next `digi` = 12'hFFF; counter and digit are reset to 0.
  - `reset` overrides everything in the same edge.

## Timing
- `digi` is registered: it reflects counter/digit/shadow state one cycle after that state.
- After the edge that sets enable, the first non-blank `digi` appears `BLANK_CYC`+1 edges later.
- Each digit is lit for `SCAN_DIV`-`BLANK_CYC` cycles per slot; frame period = 4·`SCAN_DIV`.
- `mem_rdata` is valid the cycle after `mem_re` and holds until the next `mem_re`.
- `mem_we` and `mem_re` asserted together: the write takes effect and the read returns pre-write contents.

## Structure
- **Shared package `digi_pkg`:**
  - Register address constants (VALUE = 0, CTRL = 1, STATUS = 2).
  - `digi` field positions (anode `[11:8]`, dp 7, seg `[6:0]`).
  - `DIGI_OFF` = 12'hFFF.
  - Typedef for the 2-bit digit index.
- **Sub-module `seg7_hex_decode`:** combinational nibble → 7-bit active-low segments.
- Register file, counter, and buffering stay in `digi_scan_driver`.

## Test plan
All scenarios use `SCAN_DIV`=8, `BLANK_CYC`=2.
- **Reset:** assert `reset` 2 cycles → `digi` = 12'hFFF, read VALUE/CTRL/STATUS = 0.
- **Basic scan:** write VALUE = 16'h12AF, CTRL = 9'h100. Then:
  - Slot 0 lit: `digi` = 12'hE8E.
  - Slot 1: `digi` = 12'hD88.
  - Slot 2: `digi` = 12'hBA4.
  - Slot 3: `digi` = 12'h7F9.
  - Each lit for 6 cycles after 2 cycles of 12'hFFF.
- **Masks:** CTRL = 9'h1_1_2 (enable, dp on digit 0, blank digit 1) → digit 0 shows `digi` bit 7 = 0; slot 1 stays 12'hFFF.
- **Tear-free update:** write VALUE = 16'h0000 mid-frame during digit 1 → digits 2 and 3 still show the old nibbles; zeros appear from the next frame; a write on the exact boundary cycle is deferred one frame.
- **frame_done:** read STATUS after one full frame → bit 2 = 1; immediate re-read → 0; a read coincident with the boundary leaves it 1.
- **Disable/reset mid-slot:** clear enable during digit 2 → `digi` = 12'hFFF next cycle and STATUS digit = 0. Re-enable → scan restarts at digit 0. `reset` mid-frame gives the same result and clears VALUE.

Source files
------------

// File: rtl/digi_pkg.sv
// digi_pkg: shared constants and types for the four-digit scan driver.
// Register map, digi bus field positions and the digit index type.
package digi_pkg;

    localparam logic [1:0] ADDR_VALUE  = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int DIGI_AN_MSB  = 11;
    localparam int DIGI_AN_LSB  = 8;
    localparam int DIGI_DP      = 7;
    localparam int DIGI_SEG_MSB = 6;

    localparam int CTRL_EN = 8;

    localparam logic [11:0] DIGI_OFF = 12'hFFF;

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-low gfedcba segment pattern.
// Purely combinational, shared hex glyph table.
module seg7_hex_decode (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Glyph lookup, bit 0 = segment a
    always_comb begin
        seg_o = 7'h7F;
        unique case (nib_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/digi_scan_driver.sv
// digi_scan_driver: memory-mapped four-digit seven-segment scanner.
// Pending VALUE/CTRL are copied to a shadow only at frame boundaries.
module digi_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [1:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic [11:0] digi
);

    import digi_pkg::*;

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    logic [15:0]   value_q, value_d;
    logic [8:0]    ctrl_q, ctrl_d;
    logic [15:0]   sh_value_q, sh_value_d;
    logic [3:0]    sh_blank_q, sh_blank_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    dig_q, dig_d;
    logic          frame_done_q, frame_done_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [11:0]   digi_q, digi_d;

    logic       run;
    logic       slot_end;
    logic       frame_end;
    logic       rd_status;
    logic       lit;
    logic [3:0] nib;
    logic [6:0] seg;

    wire unused_wdata = &{1'b0, mem_wdata[31:16]};

    seg7_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (seg)
    );

    // CPU writes to the pending registers
    always_comb begin
        value_d = value_q;
        ctrl_d  = ctrl_q;
        if (mem_we) begin
            if (mem_addr == ADDR_VALUE) begin
                value_d = mem_wdata[15:0];
            end else if (mem_addr == ADDR_CTRL) begin
                ctrl_d = mem_wdata[8:0];
            end
        end
    end

    // Scan runs only while enable is held across the edge
    always_comb begin
        run       = ctrl_q[CTRL_EN] && ctrl_d[CTRL_EN];
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = run && slot_end && (dig_q == 2'd3);
        rd_status = mem_re && (mem_addr == ADDR_STATUS);
    end

    // Slot counter and digit index
    always_comb begin
        cnt_d = cnt_q;
        dig_d = dig_q;
        if (!run) begin
            cnt_d = '0;
            dig_d = '0;
        end else if (slot_end) begin
            cnt_d = '0;
            dig_d = dig_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Shadow tracks pending while idle, else loads at frame wrap
    always_comb begin
        sh_value_d = sh_value_q;
        sh_blank_d = sh_blank_q;
        sh_dp_d    = sh_dp_q;
        if (!ctrl_q[CTRL_EN] || frame_end) begin
            sh_value_d = value_q;
            sh_blank_d = ctrl_q[3:0];
            sh_dp_d    = ctrl_q[7:4];
        end
    end

    // Sticky frame flag; a new frame wins over a clearing read
    always_comb begin
        frame_done_d = frame_done_q;
        if (frame_end) begin
            frame_done_d = 1'b1;
        end else if (rd_status) begin
            frame_done_d = 1'b0;
        end
    end

    // Read mux samples pre-write contents
    always_comb begin
        rdata_d = rdata_q;
        if (mem_re) begin
            rdata_d = '0;
            if (mem_addr == ADDR_VALUE) begin
                rdata_d = {16'h0, value_q};
            end else if (mem_addr == ADDR_CTRL) begin
                rdata_d = {23'h0, ctrl_q};
            end else if (mem_addr == ADDR_STATUS) begin
                rdata_d = {29'h0, frame_done_q, dig_q};
            end
        end
    end

    // Current digit nibble select
    always_comb begin
        nib = sh_value_q[3:0];
        unique case (dig_q)
            2'd0: nib = sh_value_q[3:0];
            2'd1: nib = sh_value_q[7:4];
            2'd2: nib = sh_value_q[11:8];
            2'd3: nib = sh_value_q[15:12];
            default: nib = sh_value_q[3:0];
        endcase
    end

    // Display word for the current slot position
    always_comb begin
        lit    = run && (cnt_q >= BLANK_END) && !sh_blank_q[dig_q];
        digi_d = DIGI_OFF;
        if (lit) begin
            digi_d[DIGI_AN_MSB:DIGI_AN_LSB] = ~(4'b0001 << dig_q);
            digi_d[DIGI_DP]                 = ~sh_dp_q[dig_q];
            digi_d[DIGI_SEG_MSB:0]          = seg;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q      <= '0;
            ctrl_q       <= '0;
            sh_value_q   <= '0;
            sh_blank_q   <= '0;
            sh_dp_q      <= '0;
            cnt_q        <= '0;
            dig_q        <= '0;
            frame_done_q <= 1'b0;
            rdata_q      <= '0;
            digi_q       <= DIGI_OFF;
        end else begin
            value_q      <= value_d;
            ctrl_q       <= ctrl_d;
            sh_value_q   <= sh_value_d;
            sh_blank_q   <= sh_blank_d;
            sh_dp_q      <= sh_dp_d;
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
            rdata_q      <= rdata_d;
            digi_q       <= digi_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign digi      = digi_q;

endmodule
